shift_pipe: RTL and testbench

- Pipelined, elastic successor to the combinational shifter.
- Performs SLL/SRL/SRA, plus optional rotates, on a WIDTH_P-bit operand.
- The log2(WIDTH_P) barrel-shift levels are spread across STAGES_P register stages, with a valid/ready handshake at both ends.
- Sits between the pixel datapath and downstream scaling/normalisation logic in the Sobel pipeline; intended to close timing at wide widths.

---
 rtl/shift_pipe.sv | 158 +++++++++++++++
 tb/tb_shift_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe
// Brief    : Elastic, pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR).
//            The log2(WIDTH_P) shift levels are spread across STAGES_P
//            register stages; valid/ready handshake on both ends.
//            Optional feature macro: SHIFT_PIPE_ROTATE_EN (enables ops 3/4).
// Revision : 1.0 - initial release
// ============================================================================
module shift_pipe #(
  parameter int WIDTH_P       = 32,
  parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P),
  parameter int STAGES_P      = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WIDTH_P-1:0]       data_i,
  input  logic [SHAMT_WIDTH_P-1:0] shamt_i,
  input  logic [2:0]               op_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [WIDTH_P-1:0]       data_o,
  output logic [2:0]               op_o
);

  localparam logic [2:0] c_OP_SLL = 3'd0;
  localparam logic [2:0] c_OP_SRL = 3'd1;
  localparam logic [2:0] c_OP_SRA = 3'd2;
`ifdef SHIFT_PIPE_ROTATE_EN
  localparam logic [2:0] c_OP_ROL = 3'd3;
  localparam logic [2:0] c_OP_ROR = 3'd4;
`endif

  // Elaboration-time parameter legality checks
  if (WIDTH_P < 2 || (WIDTH_P & (WIDTH_P - 1)) != 0) begin : g_bad_width
    $error("shift_pipe: WIDTH_P must be a power of two >= 2");
  end
  if (SHAMT_WIDTH_P != $clog2(WIDTH_P)) begin : g_bad_shamt
    $error("shift_pipe: SHAMT_WIDTH_P must equal clog2(WIDTH_P)");
  end
  if (STAGES_P < 1 || STAGES_P > SHAMT_WIDTH_P) begin : g_bad_stages
    $error("shift_pipe: STAGES_P must lie in 1..SHAMT_WIDTH_P");
  end

  // One barrel level: shift d by the constant amount amt according to op.
  // Right-arithmetic fill comes from the sign bit captured at entry, so the
  // level result does not depend on an already-shifted MSB.
  function automatic logic [WIDTH_P-1:0] f_level(
    input logic [WIDTH_P-1:0] d,
    input logic [2:0]         op,
    input logic               fill,
    input int                 amt
  );
    logic [WIDTH_P-1:0] m_vac;
    m_vac   = ~({WIDTH_P{1'b1}} >> amt);
    f_level = d;
    case (op)
      c_OP_SLL: f_level = d << amt;
      c_OP_SRL: f_level = d >> amt;
      c_OP_SRA: f_level = (d >> amt) | (fill ? m_vac : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
      c_OP_ROL: f_level = (d << amt) | (d >> (WIDTH_P - amt));
      c_OP_ROR: f_level = (d >> amt) | (d << (WIDTH_P - amt));
`endif
      default:  f_level = d;
    endcase
  endfunction

  // Registered outputs of every stage, gathered for the next stage to read
  logic [STAGES_P-1:0]      w_q_valid;
  logic [STAGES_P-1:0]      w_q_fill;
  logic [WIDTH_P-1:0]       w_q_data  [STAGES_P];
  logic [SHAMT_WIDTH_P-1:0] w_q_shamt [STAGES_P];
  logic [2:0]               w_q_op    [STAGES_P];

  for (genvar s = 0; s < STAGES_P; s++) begin : g_stage
    logic                     w_up_valid;
    logic                     w_up_fill;
    logic [WIDTH_P-1:0]       w_up_data;
    logic [SHAMT_WIDTH_P-1:0] w_up_shamt;
    logic [2:0]               w_up_op;
    logic                     w_ready;
    logic [WIDTH_P-1:0]       w_res;

    logic                     r_valid;
    logic                     r_fill;
    logic [WIDTH_P-1:0]       r_data;
    logic [SHAMT_WIDTH_P-1:0] r_shamt;
    logic [2:0]               r_op;

    if (s == 0) begin : g_entry
      assign w_up_valid = valid_i;
      assign w_up_fill  = data_i[WIDTH_P-1];
      assign w_up_data  = data_i;
      assign w_up_shamt = shamt_i;
      assign w_up_op    = op_i;
    end else begin : g_link
      assign w_up_valid = w_q_valid[s-1];
      assign w_up_fill  = w_q_fill[s-1];
      assign w_up_data  = w_q_data[s-1];
      assign w_up_shamt = w_q_shamt[s-1];
      assign w_up_op    = w_q_op[s-1];
    end

    // The ready chain !v[s] | ready[s+1] unrolled: a stage can load unless it
    // and every stage after it is full while the sink is stalling.
    assign w_ready = ready_i | ~(&w_q_valid[STAGES_P-1:s]);

    // Apply the barrel levels k with floor(k*STAGES_P/SHAMT_WIDTH_P) == s
    always_comb begin
      w_res = w_up_data;
      for (int k = 0; k < SHAMT_WIDTH_P; k++) begin
        if (((k * STAGES_P) / SHAMT_WIDTH_P) == s && w_up_shamt[k]) begin
          w_res = f_level(w_res, w_up_op, w_up_fill, 1 << k);
        end
      end
    end

    // Stage register: valid follows upstream whenever the stage may load;
    // payload is only captured alongside a valid operand.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        r_valid <= 1'b0;
        r_fill  <= 1'b0;
        r_data  <= '0;
        r_shamt <= '0;
        r_op    <= '0;
      end else if (w_ready) begin
        r_valid <= w_up_valid;
        if (w_up_valid) begin
          r_fill  <= w_up_fill;
          r_data  <= w_res;
          r_shamt <= w_up_shamt;
          r_op    <= w_up_op;
        end
      end
    end

    assign w_q_valid[s] = r_valid;
    assign w_q_fill[s]  = r_fill;
    assign w_q_data[s]  = r_data;
    assign w_q_shamt[s] = r_shamt;
    assign w_q_op[s]    = r_op;
  end

  assign ready_o = g_stage[0].w_ready;
  assign valid_o = w_q_valid[STAGES_P-1];
  assign data_o  = w_q_data[STAGES_P-1];
  assign op_o    = w_q_op[STAGES_P-1];

  // The final stage's shift amount and fill bit have no consumer
  logic w_unused;
  assign w_unused = ^{w_q_shamt[STAGES_P-1], w_q_fill[STAGES_P-1]};

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Self-checking bench for shift_pipe: directed literal cases,
//            stall/ordering, mid-flight reset and randomized traffic against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;
  localparam int W      = 32;
  localparam int SW     = 5;
  localparam int STAGES = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_i;
  logic [SW-1:0] shamt_i;
  logic [2:0]    op_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic [2:0]    op_o;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH_P(W), .SHAMT_WIDTH_P(SW), .STAGES_P(STAGES)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .op_i    (op_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .op_o    (op_o)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   op;
    int           acc;
  } item_t;

  item_t        q[$];
  logic [W-1:0] got[$];
  int           n_pass  = 0;
  int           n_total = 0;
  int           cyc     = 0;
  bit           mon_en  = 0;
  bit           held    = 0;
  bit           seen_full = 0;
  logic [W-1:0] prev_data;
  logic [2:0]   prev_op;

  // Reference shift computed directly from the operation definitions
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int sh,
                                             input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = $signed(d) >>> sh;
`ifdef SHIFT_PIPE_ROTATE_EN
      3'd3: r = (d << sh) | (d >> (W - sh));
      3'd4: r = (d >> sh) | (d << (W - sh));
`endif
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every cycle check handshake and result against the model.
  // The oldest in-flight operand must be on the output exactly when it has
  // been in the pipe for STAGES cycles; the block refuses input only when it
  // holds STAGES operands and the sink is stalling.
  always @(negedge clk) begin
    if (mon_en) begin
      item_t it;
      chk("ready_o", ready_o, ready_i || (q.size() < STAGES));
      chk("valid_o", valid_o, (q.size() > 0) && (cyc - q[0].acc >= STAGES));
      if (valid_o && q.size() > 0) begin
        chk("data_o", data_o, q[0].data);
        chk("op_o", op_o, q[0].op);
      end
      if (held) begin
        chk("hold_data", data_o, prev_data);
        chk("hold_op", op_o, prev_op);
      end
      if (!ready_o) seen_full = 1;
      held      = valid_o && !ready_i;
      prev_data = data_o;
      prev_op   = op_o;
      if (reset_i) begin
        q.delete();
        held = 0;
      end else begin
        if (valid_o && ready_i && q.size() > 0) begin
          got.push_back(data_o);
          void'(q.pop_front());
        end
        if (valid_i && ready_o) begin
          it.data = ref_shift(data_i, int'(shamt_i), op_i);
          it.op   = op_i;
          it.acc  = cyc;
          q.push_back(it);
        end
      end
    end
  end

  // Present one operand and hold it until accepted; returns at posedge+1
  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic [SW-1:0] sh);
    int n;
    n = 0;
    valid_i = 1'b1; op_i = op; data_i = d; shamt_i = sh;
    @(negedge clk);
    while (!ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      n_total++;
      $display("FAIL send_timeout: ready_o stayed %0b, required 1", ready_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Send into an idle pipe and check the literal result STAGES cycles later
  task automatic directed(input string name, input logic [2:0] op, input logic [W-1:0] d,
                          input logic [SW-1:0] sh, input logic [W-1:0] exp);
    send(op, d, sh);
    repeat (STAGES - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, valid_o, 1);
    chk(name, data_o, exp);
    chk({name, "_op"}, op_o, op);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit hold;
    reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    data_i = '0; shamt_i = '0; op_i = '0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    mon_en = 1;
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_op", op_o, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk); #1;

    directed("sll31", 3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000);
    directed("sra4_neg", 3'd2, 32'h8000_0000, 5'd4, 32'hF800_0000);
    directed("srl4", 3'd1, 32'h8000_0000, 5'd4, 32'h0800_0000);
    directed("sra4_pos", 3'd2, 32'h7000_0000, 5'd4, 32'h0700_0000);
    directed("sra0", 3'd2, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    directed("rsvd6", 3'd6, 32'h0000_1234, 5'd5, 32'h0000_1234);
`ifdef SHIFT_PIPE_ROTATE_EN
    directed("rol1", 3'd3, 32'h8000_0001, 5'd1, 32'h0000_0003);
    directed("ror1", 3'd4, 32'h0000_0001, 5'd1, 32'h8000_0000);
`else
    directed("op3_pass", 3'd3, 32'h8000_0001, 5'd1, 32'h8000_0001);
    directed("op4_pass", 3'd4, 32'h0000_0001, 5'd1, 32'h0000_0001);
`endif

    // Back-to-back stream with the sink stalled for three cycles
    got.delete();
    seen_full = 0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(3'd0, W'(i), 5'd1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    chk("stall_count", got.size(), 6);
    for (int i = 0; i < got.size(); i++) chk("stall_out", got[i], 2 * (i + 1));
    chk("stall_full_seen", seen_full, 1);

    // Reset with two operands in flight
    send(3'd0, 32'h11, 5'd1);
    send(3'd0, 32'h22, 5'd1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_op", op_o, 0);
    repeat (6) @(posedge clk);
    #1;

    // Random traffic with random backpressure, then a full-rate phase
    hold = 0;
    for (int c = 0; c < 1100; c++) begin
      if (!hold) begin
        valid_i = ($urandom_range(0, 3) != 0);
        op_i    = 3'($urandom_range(0, 7));
        data_i  = $urandom;
        shamt_i = SW'($urandom_range(0, W - 1));
      end
      ready_i = (c >= 800) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hold = valid_i && !ready_o;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
